// File: rtl/regfile_mp_pkg.sv
// ============================================================================
//  Module  : regfile_mp_pkg
//  Purpose : Shared constants and helpers for the regfile_mp register file.
//            Holds the clear-sequencer state encodings and the address
//            range-check helper used by the write and read ports.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_mp_pkg;

    // Clear-sequencer state encodings
    localparam logic [0:0] c_rf_st_clear = 1'b0;
    localparam logic [0:0] c_rf_st_ready = 1'b1;

    // True when an address falls outside the populated part of the array
    function automatic logic addr_oob(input logic [31:0] addr, input int unsigned depth);
        return (addr >= depth);
    endfunction

endpackage : regfile_mp_pkg

`default_nettype wire

// File: rtl/regfile_clr_fsm.sv
// ============================================================================
//  Module  : regfile_clr_fsm
//  Purpose : Clear sequencer for regfile_mp. After reset release, or on a
//            clr_req pulse while READY, walks every entry once and issues a
//            zero-write for each, holding busy high until done.
//  Ports   : clk        - clock, rising edge
//            reset      - asynchronous reset, active low
//            i_clr_req  - one-cycle request to re-clear the array
//            o_busy     - high while the clear walk runs
//            o_clr_we   - zero-write strobe for the array
//            o_clr_addr - entry being cleared this cycle
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_clr_fsm
    import regfile_mp_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clr_req,
    output logic              o_busy,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr
);

    localparam logic [ADDR_W-1:0] c_last = ADDR_W'(DEPTH - 1);

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [ADDR_W-1:0] w_clr_ptr_nxt;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= c_rf_st_clear;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_ptr <= w_clr_ptr_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        case (r_state)
            c_rf_st_clear: begin
                if (r_clr_ptr == c_last) begin
                    w_state_nxt   = c_rf_st_ready;
                    w_clr_ptr_nxt = '0;
                end else begin
                    w_clr_ptr_nxt = r_clr_ptr + 1'b1;
                end
            end
            default: begin
                if (i_clr_req) begin
                    w_state_nxt   = c_rf_st_clear;
                    w_clr_ptr_nxt = '0;
                end
            end
        endcase
    end

    // Output logic
    always_comb begin
        o_busy     = (r_state == c_rf_st_clear);
        o_clr_we   = (r_state == c_rf_st_clear);
        o_clr_addr = r_clr_ptr;
    end

endmodule : regfile_clr_fsm

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
//  Module  : regfile_mp
//  Purpose : 1-write / 2-read register file with registered reads, a valid
//            flag per read port, a built-in clear sequencer and an
//            out-of-range access flag.
//  Ports   : clk, reset (async, active low), clr_req, busy,
//            we/waddr/wdata          - write port (from writeback)
//            rdN_en/rdN_addr         - read requests, N = 0,1
//            rdN_data/rdN_valid      - registered read results
//            addr_err                - pulse: accepted access hit addr>=DEPTH
//  Config  : REGFILE_BYPASS_EN - when defined, a read of the address being
//            written in the same cycle returns the new write data.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    output logic              busy,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd0_en,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic [DATA_W-1:0] rd0_data,
    output logic              rd0_valid,
    input  logic              rd1_en,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    output logic              rd1_valid,
    output logic              addr_err
);

`ifdef REGFILE_BYPASS_EN
    localparam bit c_bypass = 1'b1;
`else
    localparam bit c_bypass = 1'b0;
`endif

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_waddr_oob;
    logic              w_rd0_oob;
    logic              w_rd1_oob;
    logic [DATA_W-1:0] w_rd0_val;
    logic [DATA_W-1:0] w_rd1_val;
    logic              w_err;

    logic [DATA_W-1:0] r_rd0_data;
    logic [DATA_W-1:0] r_rd1_data;
    logic              r_rd0_valid;
    logic              r_rd1_valid;
    logic              r_addr_err;

    regfile_clr_fsm #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clr_fsm (
        .clk        (clk),
        .reset      (reset),
        .i_clr_req  (clr_req),
        .o_busy     (w_busy),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    always_comb begin
        w_waddr_oob = addr_oob(32'(waddr), DEPTH);
        w_rd0_oob   = addr_oob(32'(rd0_addr), DEPTH);
        w_rd1_oob   = addr_oob(32'(rd1_addr), DEPTH);
    end

    // The clear walk owns the write port while it runs; user writes only
    // reach the array in READY.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (we && !w_waddr_oob) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Read data selection. Out-of-range reads return zero; with bypass a
    // same-address write is forwarded instead of the stale array contents.
    always_comb begin
        w_rd0_val = w_rd0_oob ? '0 : r_mem[rd0_addr];
        w_rd1_val = w_rd1_oob ? '0 : r_mem[rd1_addr];
        if (c_bypass && we && !w_waddr_oob) begin
            if (rd0_addr == waddr) begin
                w_rd0_val = wdata;
            end
            if (rd1_addr == waddr) begin
                w_rd1_val = wdata;
            end
        end
    end

    // All offenders in one cycle collapse into a single flag
    always_comb begin
        w_err = !w_busy && ((we && w_waddr_oob) ||
                            (rd0_en && w_rd0_oob) ||
                            (rd1_en && w_rd1_oob));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd0_data  <= '0;
            r_rd1_data  <= '0;
            r_rd0_valid <= 1'b0;
            r_rd1_valid <= 1'b0;
            r_addr_err  <= 1'b0;
        end else begin
            r_rd0_valid <= !w_busy && rd0_en;
            r_rd1_valid <= !w_busy && rd1_en;
            r_addr_err  <= w_err;
            if (!w_busy && rd0_en) begin
                r_rd0_data <= w_rd0_val;
            end
            if (!w_busy && rd1_en) begin
                r_rd1_data <= w_rd1_val;
            end
        end
    end

    assign busy      = w_busy;
    assign rd0_data  = r_rd0_data;
    assign rd1_data  = r_rd1_data;
    assign rd0_valid = r_rd0_valid;
    assign rd1_valid = r_rd1_valid;
    assign addr_err  = r_addr_err;

endmodule : regfile_mp

`default_nettype wire
